mult_feeder: RTL

MULT_FEEDER -- requirements
Module: mult_feeder

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_feeder_if.sv | 30 +++
 rtl/mult_feeder_mem.sv | 25 ++
 rtl/mult_feeder.sv | 86 ++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared sizing constants and helpers for the multiplier feed path.
package mult_pkg;

  localparam int unsigned SAMPLE_W       = 8;
  localparam int unsigned FEED_DEPTH     = 4;
  localparam int unsigned UNDERRUN_CNT_W = 8;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mult_feeder_if.sv
// Producer push handshake plus multiplier grant/operand path.
interface mult_feeder_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             input_grant;
  logic [WIDTH-1:0] d;

  modport master (
    output in_data,
    output in_valid,
    output input_grant,
    input  in_ready,
    input  d
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  input_grant,
    output in_ready,
    output d
  );

endinterface

// File: rtl/mult_feeder_mem.sv
// Sample storage: register array, one write port, asynchronous read port.
module mult_feeder_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mult_feeder.sv
// Sample FIFO feeding a multiplier operand; pops on grant, tracks underruns.
module mult_feeder
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = FEED_DEPTH,
  parameter int unsigned WIDTH = SAMPLE_W,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  mult_feeder_if.slave              bus,
  input  logic                      clr_underrun,
  output logic [LW-1:0]             level,
  output logic                      full,
  output logic                      empty,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  logic [AW-1:0]             wptr_q, wptr_d;
  logic [AW-1:0]             rptr_q, rptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      underrun_q, underrun_d;
  logic [UNDERRUN_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]          head;
  logic                      push, pop, und_evt;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  // A pop never frees a slot for a same-cycle push: in_ready depends on state only.
  assign push    = bus.in_valid && !full;
  assign pop     = bus.input_grant && !empty;
  assign und_evt = bus.input_grant && empty;

  always_comb begin
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    underrun_d = underrun_q;
    cnt_d      = cnt_q;
    if (clr_underrun) begin
      underrun_d = und_evt;
      cnt_d      = und_evt ? UNDERRUN_CNT_W'(1) : '0;
    end else if (und_evt) begin
      underrun_d = 1'b1;
      cnt_d      = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  mult_feeder_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  // Stale storage is masked so d reads zero whenever nothing is queued.
  assign bus.d        = empty ? '0 : head;
  assign bus.in_ready = !full;
  assign level        = level_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;

endmodule
